// File: rtl/ddr5_pkg.sv
`default_nettype none
// ============================================================================
// Module : ddr5_pkg
// Brief  : Shared types and default timings for the DDR5 command responder.
// Rev    : 1.0
// ============================================================================
package ddr5_pkg;

    localparam int NUM_BANKS = 32;
    localparam int DEF_T_RCD = 39;
    localparam int DEF_T_RP  = 39;
    localparam int DEF_T_CL  = 40;
    localparam int DEF_T_CWL = 38;

    typedef enum logic [2:0] {
        CMD_NOP  = 3'd0,
        CMD_ACT0 = 3'd1,
        CMD_ACT1 = 3'd2,
        CMD_RD   = 3'd3,
        CMD_WR   = 3'd4,
        CMD_PRE  = 3'd5
    } cmd_e;

    typedef enum logic [2:0] {
        BS_IDLE     = 3'd0,
        BS_ACT_HALF = 3'd1,
        BS_OPENING  = 3'd2,
        BS_ACTIVE   = 3'd3,
        BS_CLOSING  = 3'd4
    } bank_state_e;

    typedef enum logic [2:0] {
        ERR_NONE       = 3'd0,
        ERR_ACT_BUSY   = 3'd1,
        ERR_ACT_SEQ    = 3'd2,
        ERR_COL_CLOSED = 3'd3,
        ERR_COL_EARLY  = 3'd4,
        ERR_PRE_BUSY   = 3'd5
    } err_e;

    typedef struct packed {
        logic [2:0]  bg;
        logic [1:0]  bank;
        logic [15:0] row;
        logic [10:0] col;
    } bank_addr_t;

    // Per-bank legality summary; anything neither idle, active nor early is closing.
    typedef struct packed {
        logic idle;
        logic active;
        logic col_early;
    } bank_legal_t;

    typedef struct packed {
        logic       valid;
        bank_addr_t addr;
    } rd_entry_t;

endpackage
`default_nettype wire

// File: rtl/ddr5_bank_fsm.sv
`default_nettype none
// ============================================================================
// Module : ddr5_bank_fsm
// Brief  : One DRAM bank: state, activate/precharge timer and open row.
// Rev    : 1.0
// ============================================================================
module ddr5_bank_fsm
    import ddr5_pkg::*;
#(
    parameter int T_RCD = DEF_T_RCD,
    parameter int T_RP  = DEF_T_RP
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_act0,
    input  logic        i_act1,
    input  logic        i_pre,
    input  logic [15:0] i_row,
    output bank_legal_t o_legal,
    output logic [15:0] o_open_row
);

    localparam logic [2:0] ST_IDLE     = BS_IDLE;
    localparam logic [2:0] ST_ACT_HALF = BS_ACT_HALF;
    localparam logic [2:0] ST_OPENING  = BS_OPENING;
    localparam logic [2:0] ST_ACTIVE   = BS_ACTIVE;
    localparam logic [2:0] ST_CLOSING  = BS_CLOSING;

    // Leaving on count 1 makes the bank usable exactly T cycles after the command.
    localparam logic [6:0] c_RCD_LOAD = 7'(T_RCD - 1);
    localparam logic [6:0] c_RP_LOAD  = 7'(T_RP - 1);

    logic [2:0]  r_state;
    logic [6:0]  r_cnt;
    logic [15:0] r_open_row;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_cnt      <= 7'd0;
            r_open_row <= 16'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_act0) begin
                        r_state    <= ST_ACT_HALF;
                        r_open_row <= i_row;
                    end
                end
                ST_ACT_HALF: begin
                    if (i_act1) begin
                        r_state <= ST_OPENING;
                        r_cnt   <= c_RCD_LOAD;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_OPENING: begin
                    if (r_cnt <= 7'd1) begin
                        r_state <= ST_ACTIVE;
                        r_cnt   <= 7'd0;
                    end else begin
                        r_cnt <= r_cnt - 7'd1;
                    end
                end
                ST_ACTIVE: begin
                    if (i_pre) begin
                        r_state <= ST_CLOSING;
                        r_cnt   <= c_RP_LOAD;
                    end
                end
                ST_CLOSING: begin
                    if (r_cnt <= 7'd1) begin
                        r_state <= ST_IDLE;
                        r_cnt   <= 7'd0;
                    end else begin
                        r_cnt <= r_cnt - 7'd1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign o_legal.idle      = (r_state == ST_IDLE);
    assign o_legal.active    = (r_state == ST_ACTIVE);
    assign o_legal.col_early = (r_state == ST_ACT_HALF) || (r_state == ST_OPENING);
    assign o_open_row        = r_open_row;

endmodule
`default_nettype wire

// File: rtl/ddr5_cmd_responder.sv
`default_nettype none
// ============================================================================
// Module : ddr5_cmd_responder
// Brief  : Decodes the scheduler command stream, checks it, returns completions.
// Rev    : 1.0
// ============================================================================
module ddr5_cmd_responder
    import ddr5_pkg::*;
#(
    parameter int CHANNEL_ID = 0,
    parameter int T_RCD      = DEF_T_RCD,
    parameter int T_RP       = DEF_T_RP,
    parameter int T_CL       = DEF_T_CL,
    parameter int T_CWL      = DEF_T_CWL
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_cmd_valid,
    input  logic [2:0]  i_cmd,
    input  logic        i_cmd_channel,
    input  logic [2:0]  i_cmd_bg,
    input  logic [1:0]  i_cmd_bank,
    input  logic [15:0] i_cmd_row,
    input  logic [10:0] i_cmd_col,
    output logic        o_rd_valid,
    output logic [2:0]  o_rd_bg,
    output logic [1:0]  o_rd_bank,
    output logic [15:0] o_rd_row,
    output logic [10:0] o_rd_col,
    output logic        o_wr_ack,
    output logic        o_err_valid,
    output logic [2:0]  o_err_code
);

    bank_legal_t w_legal    [NUM_BANKS];
    logic [15:0] w_open_row [NUM_BANKS];
    logic [4:0]  w_idx;
    bank_legal_t w_sel;
    logic        w_live;
    err_e        w_err;
    logic        w_do_act0, w_do_act1, w_do_pre, w_do_rd, w_do_wr;
    rd_entry_t   w_rd_new;

    logic             r_half_valid;
    logic [4:0]       r_half_idx;
    rd_entry_t        r_rd_pipe [T_CL];
    logic [T_CWL-1:0] r_wr_pipe;
    logic             r_err_valid;
    err_e             r_err_code;

    assign w_idx  = {i_cmd_bg, i_cmd_bank};
    assign w_sel  = w_legal[w_idx];
    assign w_live = i_cmd_valid && (i_cmd_channel == 1'(CHANNEL_ID))
                 && (i_cmd >= CMD_ACT0) && (i_cmd <= CMD_PRE);

    // The cycle after an accepted ACT0 only admits the matching ACT1.
    always_comb begin
        w_err     = ERR_NONE;
        w_do_act0 = 1'b0;
        w_do_act1 = 1'b0;
        w_do_pre  = 1'b0;
        w_do_rd   = 1'b0;
        w_do_wr   = 1'b0;
        w_rd_new  = '0;
        if (w_live) begin
            if (r_half_valid && !((i_cmd == CMD_ACT1) && (w_idx == r_half_idx))) begin
                w_err = ERR_ACT_SEQ;
            end else begin
                case (i_cmd)
                    CMD_ACT0: if (w_sel.idle) w_do_act0 = 1'b1; else w_err = ERR_ACT_BUSY;
                    CMD_ACT1: if (r_half_valid) w_do_act1 = 1'b1; else w_err = ERR_ACT_SEQ;
                    CMD_RD, CMD_WR: begin
                        if (w_sel.active) begin
                            w_do_rd = (i_cmd == CMD_RD);
                            w_do_wr = (i_cmd == CMD_WR);
                        end else if (w_sel.col_early) begin
                            w_err = ERR_COL_EARLY;
                        end else begin
                            w_err = ERR_COL_CLOSED;
                        end
                    end
                    CMD_PRE: begin
                        if (w_sel.active)    w_do_pre = 1'b1;
                        else if (!w_sel.idle) w_err   = ERR_PRE_BUSY;
                    end
                    default: ;
                endcase
            end
        end
        if (w_do_rd) begin
            w_rd_new.valid     = 1'b1;
            w_rd_new.addr.bg   = i_cmd_bg;
            w_rd_new.addr.bank = i_cmd_bank;
            w_rd_new.addr.row  = w_open_row[w_idx];
            w_rd_new.addr.col  = i_cmd_col;
        end
    end

    for (genvar gi = 0; gi < NUM_BANKS; gi++) begin : g_bank
        ddr5_bank_fsm #(
            .T_RCD (T_RCD),
            .T_RP  (T_RP)
        ) u_bank (
            .clk        (clk),
            .rst_n      (rst_n),
            .i_act0     (w_do_act0 && (w_idx == 5'(gi))),
            .i_act1     (w_do_act1 && (w_idx == 5'(gi))),
            .i_pre      (w_do_pre  && (w_idx == 5'(gi))),
            .i_row      (i_cmd_row),
            .o_legal    (w_legal[gi]),
            .o_open_row (w_open_row[gi])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_half_valid <= 1'b0;
            r_half_idx   <= 5'd0;
            r_err_valid  <= 1'b0;
            r_err_code   <= ERR_NONE;
            r_wr_pipe    <= '0;
            for (int k = 0; k < T_CL; k++) r_rd_pipe[k] <= '0;
        end else begin
            r_half_valid <= w_do_act0;
            r_half_idx   <= w_idx;
            r_err_valid  <= (w_err != ERR_NONE);
            r_err_code   <= w_err;
            r_wr_pipe    <= {r_wr_pipe[T_CWL-2:0], w_do_wr};
            r_rd_pipe[0] <= w_rd_new;
            for (int k = 1; k < T_CL; k++) r_rd_pipe[k] <= r_rd_pipe[k-1];
        end
    end

    assign o_rd_valid  = r_rd_pipe[T_CL-1].valid;
    assign o_rd_bg     = r_rd_pipe[T_CL-1].addr.bg;
    assign o_rd_bank   = r_rd_pipe[T_CL-1].addr.bank;
    assign o_rd_row    = r_rd_pipe[T_CL-1].addr.row;
    assign o_rd_col    = r_rd_pipe[T_CL-1].addr.col;
    assign o_wr_ack    = r_wr_pipe[T_CWL-1];
    assign o_err_valid = r_err_valid;
    assign o_err_code  = r_err_code;

endmodule
`default_nettype wire

// File: tb/tb_ddr5_cmd_responder.sv
`default_nettype none
// ============================================================================
// Module : tb_ddr5_cmd_responder
// Brief  : Directed and randomized checks against a timestamp-based bank model.
// Rev    : 1.0
// ============================================================================
module tb_ddr5_cmd_responder;

    localparam int T_RCD = 39;
    localparam int T_RP  = 39;
    localparam int T_CL  = 40;
    localparam int T_CWL = 38;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic [2:0]  cmd = 3'd0;
    logic        cmd_channel = 1'b0;
    logic [2:0]  cmd_bg = 3'd0;
    logic [1:0]  cmd_bank = 2'd0;
    logic [15:0] cmd_row = 16'd0;
    logic [10:0] cmd_col = 11'd0;
    logic        rd_valid, wr_ack, err_valid;
    logic [2:0]  rd_bg, err_code;
    logic [1:0]  rd_bank;
    logic [15:0] rd_row;
    logic [10:0] rd_col;
    logic [37:0] all_outs;

    assign all_outs = {rd_valid, rd_bg, rd_bank, rd_row, rd_col, wr_ack, err_valid, err_code};

    ddr5_cmd_responder #(
        .CHANNEL_ID (0), .T_RCD (T_RCD), .T_RP (T_RP), .T_CL (T_CL), .T_CWL (T_CWL)
    ) dut (
        .clk (clk), .rst_n (rst_n),
        .i_cmd_valid (cmd_valid), .i_cmd (cmd), .i_cmd_channel (cmd_channel),
        .i_cmd_bg (cmd_bg), .i_cmd_bank (cmd_bank), .i_cmd_row (cmd_row), .i_cmd_col (cmd_col),
        .o_rd_valid (rd_valid), .o_rd_bg (rd_bg), .o_rd_bank (rd_bank), .o_rd_row (rd_row),
        .o_rd_col (rd_col), .o_wr_ack (wr_ack), .o_err_valid (err_valid), .o_err_code (err_code)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_fail = 0;

    // Reference model: bank legality derived from command timestamps.
    typedef struct { int due; logic [31:0] tag; } rd_ev_t;
    rd_ev_t      rd_q[$];
    int          wr_q[$];
    int          cyc;
    logic        m_open [32];
    int          m_act1_t [32];
    int          m_pre_t [32];
    logic [15:0] m_row [32];
    int          half_t, half_b;
    logic [15:0] half_row;
    logic [2:0]  exp_err;
    logic        exp_rd_v, exp_wr;
    logic [31:0] exp_rd_tag;

    task automatic model_reset();
        for (int b = 0; b < 32; b++) begin
            m_open[b] = 1'b0; m_act1_t[b] = -1000; m_pre_t[b] = -1000; m_row[b] = 16'd0;
        end
        half_t = -1000; half_b = 0; half_row = 16'd0;
        rd_q.delete(); wr_q.delete();
        cyc = 0; exp_err = 3'd0; exp_rd_v = 1'b0; exp_wr = 1'b0; exp_rd_tag = 32'd0;
    endtask

    // Drives one command cycle, advances the model and the expected outputs.
    task automatic step(input logic v, input logic [2:0] c, input logic ch, input int b,
                        input logic [15:0] row, input logic [10:0] col);
        logic [2:0] e;
        int t;
        bit halfp, closing, opening, active;
        e = 3'd0; t = cyc;
        cmd_valid = v; cmd = c; cmd_channel = ch;
        cmd_bg = 3'(b >> 2); cmd_bank = 2'(b); cmd_row = row; cmd_col = col;
        if (v && !ch && c >= 3'd1 && c <= 3'd5) begin
            halfp   = (half_t == t - 1);
            closing = (t < m_pre_t[b] + T_RP);
            opening = m_open[b] && (t < m_act1_t[b] + T_RCD);
            active  = m_open[b] && !opening;
            if (halfp && !(c == 3'd2 && b == half_b)) e = 3'd2;
            else case (c)
                3'd1: if (!m_open[b] && !closing) begin half_t = t; half_b = b; half_row = row; end
                      else e = 3'd1;
                3'd2: if (halfp) begin m_open[b] = 1'b1; m_row[b] = half_row; m_act1_t[b] = t; end
                      else e = 3'd2;
                3'd3, 3'd4: begin
                    if (active) begin
                        if (c == 3'd3) rd_q.push_back('{due: t + T_CL, tag: {5'(b), m_row[b], col}});
                        else wr_q.push_back(t + T_CWL);
                    end else if (opening) e = 3'd4;
                    else e = 3'd3;
                end
                default: if (active) begin m_open[b] = 1'b0; m_pre_t[b] = t; end
                         else if (opening || closing) e = 3'd5;
            endcase
        end
        @(posedge clk); #1;
        cyc++;
        exp_err = e; exp_rd_v = 1'b0; exp_rd_tag = 32'd0; exp_wr = 1'b0;
        if (rd_q.size() > 0 && rd_q[0].due == cyc) begin
            exp_rd_v = 1'b1; exp_rd_tag = rd_q[0].tag; void'(rd_q.pop_front());
        end
        if (wr_q.size() > 0 && wr_q[0] == cyc) begin
            exp_wr = 1'b1; void'(wr_q.pop_front());
        end
    endtask

    task automatic idle();
        step(1'b0, 3'd0, 1'b0, 0, 16'd0, 11'd0);
    endtask

    task automatic finish_reset();
        cmd_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; #1;
        n_cmp++; if (all_outs !== 38'd0) begin n_fail++; $display("FAIL reset_during: got %h want 0", all_outs); end
        finish_reset();
        n_cmp++; if (all_outs !== 38'd0) begin n_fail++; $display("FAIL reset_after: got %h want 0", all_outs); end
    endtask

    task automatic test_read_latency();
        while (cyc < 10) idle();
        step(1'b1, 3'd1, 1'b0, 9, 16'h1A2B, 11'd0);
        n_cmp++; if (err_valid !== 1'b0) begin n_fail++; $display("FAIL act0_ok: got %b want 0", err_valid); end
        step(1'b1, 3'd2, 1'b0, 9, 16'd0, 11'd0);
        while (cyc < 49) idle();
        step(1'b1, 3'd3, 1'b0, 9, 16'd0, 11'h040);
        n_cmp++; if ({err_valid, err_code} !== 4'b1100) begin n_fail++; $display("FAIL rd_early_err: got %b/%0d want 1/4", err_valid, err_code); end
        step(1'b1, 3'd3, 1'b0, 9, 16'd0, 11'h040);
        n_cmp++; if (err_valid !== 1'b0) begin n_fail++; $display("FAIL rd_retry_err: got %b want 0", err_valid); end
        while (cyc < 89) begin
            idle();
            n_cmp++; if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL rd_premature cyc %0d: got %b want 0", cyc, rd_valid); end
        end
        idle();
        n_cmp++; if ({rd_valid, rd_bg, rd_bank, rd_row, rd_col} !== {1'b1, 3'd2, 2'd1, 16'h1A2B, 11'h040})
            begin n_fail++; $display("FAIL rd_at_90: got %b %0d %0d %h %h want 1 2 1 1a2b 040", rd_valid, rd_bg, rd_bank, rd_row, rd_col); end
        idle();
        n_cmp++; if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL rd_single_pulse: got %b want 0", rd_valid); end
    endtask

    task automatic test_pre_timing();
        while (cyc < 100) idle();
        step(1'b1, 3'd5, 1'b0, 9, 16'd0, 11'd0);
        n_cmp++; if (err_valid !== 1'b0) begin n_fail++; $display("FAIL pre_ok: got %b want 0", err_valid); end
        while (cyc < 138) idle();
        step(1'b1, 3'd1, 1'b0, 9, 16'h00C3, 11'd0);
        n_cmp++; if ({err_valid, err_code} !== 4'b1001) begin n_fail++; $display("FAIL act_busy: got %b/%0d want 1/1", err_valid, err_code); end
        step(1'b1, 3'd1, 1'b0, 9, 16'h00C3, 11'd0);
        n_cmp++; if (err_valid !== 1'b0) begin n_fail++; $display("FAIL act_after_rp: got %b/%0d want 0", err_valid, err_code); end
        step(1'b1, 3'd2, 1'b0, 9, 16'd0, 11'd0);
        n_cmp++; if (err_valid !== 1'b0) begin n_fail++; $display("FAIL act1_ok: got %b/%0d want 0", err_valid, err_code); end
    endtask

    task automatic test_act_seq();
        step(1'b1, 3'd1, 1'b0, 0, 16'h0055, 11'd0);
        n_cmp++; if (err_valid !== 1'b0) begin n_fail++; $display("FAIL seq_act0: got %b want 0", err_valid); end
        step(1'b1, 3'd3, 1'b0, 0, 16'd0, 11'd1);
        n_cmp++; if ({err_valid, err_code} !== 4'b1010) begin n_fail++; $display("FAIL seq_rd_after_act0: got %b/%0d want 1/2", err_valid, err_code); end
        step(1'b1, 3'd3, 1'b0, 0, 16'd0, 11'd1);
        n_cmp++; if ({err_valid, err_code} !== 4'b1011) begin n_fail++; $display("FAIL col_closed: got %b/%0d want 1/3", err_valid, err_code); end
        step(1'b1, 3'd2, 1'b0, 0, 16'd0, 11'd0);
        n_cmp++; if ({err_valid, err_code} !== 4'b1010) begin n_fail++; $display("FAIL lone_act1: got %b/%0d want 1/2", err_valid, err_code); end
        step(1'b1, 3'd5, 1'b0, 0, 16'd0, 11'd0);
        n_cmp++; if (err_valid !== 1'b0) begin n_fail++; $display("FAIL pre_idle_nop: got %b/%0d want 0", err_valid, err_code); end
        step(1'b1, 3'd1, 1'b0, 9, 16'd0, 11'd0);
        n_cmp++; if ({err_valid, err_code} !== 4'b1001) begin n_fail++; $display("FAIL act0_opening: got %b/%0d want 1/1", err_valid, err_code); end
        step(1'b1, 3'd4, 1'b0, 9, 16'd0, 11'd0);
        n_cmp++; if ({err_valid, err_code} !== 4'b1100) begin n_fail++; $display("FAIL wr_opening: got %b/%0d want 1/4", err_valid, err_code); end
        step(1'b1, 3'd5, 1'b0, 9, 16'd0, 11'd0);
        n_cmp++; if ({err_valid, err_code} !== 4'b1101) begin n_fail++; $display("FAIL pre_opening: got %b/%0d want 1/5", err_valid, err_code); end
    endtask

    task automatic test_back_to_back();
        while (cyc < 180) idle();
        for (int k = 0; k < 8; k++) begin
            step(1'b1, 3'd3, 1'b0, 9, 16'd0, 11'(11'h100 + k));
            n_cmp++; if (err_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_err %0d: got %b/%0d want 0", k, err_valid, err_code); end
        end
        step(1'b1, 3'd4, 1'b0, 9, 16'd0, 11'd0);
        while (cyc < 220) idle();
        for (int k = 0; k < 8; k++) begin
            n_cmp++; if ({rd_valid, rd_row, rd_col} !== {1'b1, 16'h00C3, 11'(11'h100 + k)})
                begin n_fail++; $display("FAIL b2b_rd %0d: got %b %h %h want 1 00c3 %h", k, rd_valid, rd_row, rd_col, 11'h100 + k); end
            n_cmp++; if (wr_ack !== (cyc == 226)) begin n_fail++; $display("FAIL wr_ack cyc %0d: got %b want %b", cyc, wr_ack, cyc == 226); end
            idle();
        end
        n_cmp++; if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_end: got %b want 0", rd_valid); end
    endtask

    task automatic test_reset_midflight();
        int t0;
        t0 = cyc;
        for (int k = 0; k < 3; k++) step(1'b1, 3'd3, 1'b0, 9, 16'd0, 11'(k));
        step(1'b1, 3'd4, 1'b0, 9, 16'd0, 11'd0);
        while (cyc < t0 + T_CL) idle();
        n_cmp++; if (rd_valid !== 1'b1) begin n_fail++; $display("FAIL inflight_rd: got %b want 1", rd_valid); end
        #2 rst_n = 1'b0; #1;
        n_cmp++; if (all_outs !== 38'd0) begin n_fail++; $display("FAIL mid_reset_outs: got %h want 0", all_outs); end
        finish_reset();
        for (int k = 0; k < 50; k++) begin
            idle();
            n_cmp++; if ({rd_valid, wr_ack, err_valid} !== 3'b000) begin n_fail++; $display("FAIL post_reset_pulse: got %b want 000", {rd_valid, wr_ack, err_valid}); end
        end
        step(1'b1, 3'd3, 1'b1, 5, 16'd0, 11'd0);
        n_cmp++; if (err_valid !== 1'b0) begin n_fail++; $display("FAIL other_ch_rd: got %b want 0", err_valid); end
        step(1'b1, 3'd1, 1'b1, 0, 16'd0, 11'd0);
        n_cmp++; if (err_valid !== 1'b0) begin n_fail++; $display("FAIL other_ch_act0: got %b want 0", err_valid); end
        step(1'b1, 3'd2, 1'b0, 0, 16'd0, 11'd0);
        n_cmp++; if ({err_valid, err_code} !== 4'b1010) begin n_fail++; $display("FAIL other_ch_ignored: got %b/%0d want 1/2", err_valid, err_code); end
    endtask

    task automatic test_random(input int n);
        for (int i = 0; i < n; i++) begin
            int b, r;
            logic [2:0] c;
            logic ch, v;
            b  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 31)) : int'($urandom_range(0, 3)) * 9;
            r  = $urandom_range(0, 99);
            ch = ($urandom_range(0, 19) == 0);
            v  = ($urandom_range(0, 15) != 0);
            if (half_t == cyc - 1 && r < 85) begin c = 3'd2; b = half_b; end
            else if (r < 20) c = 3'd1;
            else if (r < 25) c = 3'd2;
            else if (r < 58) c = 3'd3;
            else if (r < 72) c = 3'd4;
            else if (r < 80) c = 3'd5;
            else c = 3'($urandom_range(0, 7));
            step(v, c, ch, b, 16'($urandom), 11'($urandom));
            n_cmp++; if ({err_valid, err_code} !== {(exp_err != 3'd0), exp_err})
                begin n_fail++; $display("FAIL rand_err cyc %0d: got %b/%0d want %b/%0d", cyc, err_valid, err_code, exp_err != 3'd0, exp_err); end
            n_cmp++; if ({rd_valid, (exp_rd_v ? {rd_bg, rd_bank, rd_row, rd_col} : 32'd0)} !== {exp_rd_v, exp_rd_tag})
                begin n_fail++; $display("FAIL rand_rd cyc %0d: got %b %h want %b %h", cyc, rd_valid, {rd_bg, rd_bank, rd_row, rd_col}, exp_rd_v, exp_rd_tag); end
            n_cmp++; if (wr_ack !== exp_wr) begin n_fail++; $display("FAIL rand_wr cyc %0d: got %b want %b", cyc, wr_ack, exp_wr); end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_read_latency();
        test_pre_timing();
        test_act_seq();
        test_back_to_back();
        test_reset_midflight();
        test_random(4000);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
